// File: rtl/pipelined_accumulator.sv
// Walks a wrapping window of a synchronous-read memory and folds each word into
// an accumulator (add/sub/xor/umax), one element per cycle with a one-stage pipeline.
module pipelined_accumulator #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  init_value,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_data,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [1:0]         mode_q, mode_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum, diff;

  assign sum  = acc_q + mem_data;
  assign diff = acc_q - mem_data;

  // Next-state, fold and issue logic; a start accept overrides the hold defaults.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    valid_d = (state_q == S_RUN);

    if (valid_q) begin
      unique case (mode_q)
        2'b00: begin
          acc_d = sum;
          if ((acc_q[WIDTH-1] == mem_data[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]))
            ovf_d = 1'b1;
        end
        2'b01: begin
          acc_d = diff;
          if ((acc_q[WIDTH-1] != mem_data[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]))
            ovf_d = 1'b1;
        end
        2'b10:   acc_d = acc_q ^ mem_data;
        default: acc_d = (mem_data > acc_q) ? mem_data : acc_q;
      endcase
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          len_d  = length;
          mode_d = mode;
          acc_d  = init_value;
          ovf_d  = 1'b0;
          idx_d  = '0;
          if (length != '0) begin
            state_d = S_RUN;
            addr_d  = base_addr;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (idx_q == len_q - CNT_W'(1)) begin
          state_d = S_DRAIN;
        end else begin
          idx_d  = idx_q + CNT_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: state_d = S_DONE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr = addr_q;
  assign out      = acc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pipelined_accumulator.sv
// Directed bench for pipelined_accumulator against a synchronous memory holding M[a]=a+1.
module tb_pipelined_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic [1:0]  mode;
  logic [31:0] init_value;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  pipelined_accumulator #(.WIDTH(32), .ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .mode       (mode),
    .init_value (init_value),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= 32'(mem_addr) + 32'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a start for one edge; returns in the cycle after the accepting edge.
  task automatic start_op(input logic [7:0] b, input logic [8:0] l, input logic [1:0] m,
                          input logic [31:0] iv);
    start = 1'b1; base_addr = b; length = l; mode = m; init_value = iv;
    tick();
    start = 1'b0; base_addr = 8'hAA; length = 9'd7; mode = 2'b10; init_value = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; mode = '0; init_value = '0;
    tick(); tick();
    chk("rst_out", out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Basic add: four addresses on consecutive cycles, busy for five, result 10.
    start_op(8'd0, 9'd4, 2'b00, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("add_addr", 32'(mem_addr), 32'(i));
      chk("add_busy_run", 32'(busy), 32'd1);
      chk("add_nodone", 32'(done), 32'd0);
      tick();
    end
    chk("add_busy_drain", 32'(busy), 32'd1);
    chk("add_addr_hold", 32'(mem_addr), 32'd3);
    tick();
    chk("add_done", 32'(done), 32'd1);
    chk("add_busy_off", 32'(busy), 32'd0);
    chk("add_out", out, 32'd10);
    chk("add_ovf", 32'(overflow), 32'd0);
    tick();
    chk("add_done_pulse", 32'(done), 32'd0);
    chk("add_out_hold", out, 32'd10);

    // Zero length: done immediately with the seed, never busy.
    start_op(8'd9, 9'd0, 2'b00, 32'h55);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_out", out, 32'h55);
    chk("zero_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_busy2", 32'(busy), 32'd0);

    // Wrap-around window 254,255,0,1.
    start_op(8'd254, 9'd4, 2'b00, 32'd0);
    chk("wrap_a0", 32'(mem_addr), 32'd254); tick();
    chk("wrap_a1", 32'(mem_addr), 32'd255); tick();
    chk("wrap_a2", 32'(mem_addr), 32'd0);   tick();
    chk("wrap_a3", 32'(mem_addr), 32'd1);
    wait_done("wrap_done");
    chk("wrap_out", out, 32'd514);
    tick();

    // Signed overflow on subtract, then cleared by the next start.
    start_op(8'd0, 9'd1, 2'b01, 32'h8000_0000);
    wait_done("sub_done");
    chk("sub_out", out, 32'h7FFF_FFFF);
    chk("sub_ovf", 32'(overflow), 32'd1);
    tick();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    start_op(8'd0, 9'd1, 2'b00, 32'd0);
    chk("ovf_clear", 32'(overflow), 32'd0);
    wait_done("clr_done");
    chk("clr_out", out, 32'd1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    tick();

    // Unsigned max, then a back-to-back xor started in the done cycle.
    start_op(8'd5, 9'd3, 2'b11, 32'd7);
    wait_done("max_done");
    chk("max_out", out, 32'd8);
    start_op(8'd0, 9'd2, 2'b10, 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_addr", 32'(mem_addr), 32'd0);
    chk("b2b_done_off", 32'(done), 32'd0);
    wait_done("xor_done");
    chk("xor_out", out, 32'd3);
    tick();

    // Start pulsed mid-run is ignored.
    start_op(8'd0, 9'd4, 2'b00, 32'd0);
    tick();
    start = 1'b1; base_addr = 8'd100; length = 9'd9; mode = 2'b10; init_value = 32'h1234;
    tick();
    start = 1'b0;
    chk("ign_addr", 32'(mem_addr), 32'd2);
    wait_done("ign_done");
    chk("ign_out", out, 32'd10);
    tick();
    chk("ign_idle", 32'(busy), 32'd0);

    // Reset in the second run cycle aborts without a done pulse.
    start_op(8'd0, 9'd4, 2'b00, 32'd0);
    tick();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_out", out, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_nodone", 32'(done), 32'd0);
      chk("abort_out_hold", out, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
